// File: rtl/cache_repl_pkg.sv
// cache_repl_pkg: shared types and default geometry for the cache
// replacement controller.
//   repl_state_t : controller FSM states (IDLE, RESP, FLUSH)
//   way_idx_t    : way-index field at the default N_POW
//   age_t        : per-line age counter at the default AGE_W
package cache_repl_pkg;

    localparam int DEF_N_WAYS   = 2;
    localparam int DEF_N_POW    = 4;
    localparam int DEF_N_SETS   = 16;
    localparam int DEF_SET_BITS = 4;
    localparam int DEF_AGE_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP  = 2'd1,
        FLUSH = 2'd2
    } repl_state_t;

    typedef logic [DEF_N_POW-1:0] way_idx_t;
    typedef logic [DEF_AGE_W-1:0] age_t;

endpackage

// File: rtl/cache_repl_ctrl_victim_select.sv
// victim_select: combinational way chooser for one set.
//   valid    in  per-way valid bits of the addressed set
//   ages     in  per-way ages, way i at [i*AGE_W +: AGE_W]
//   hit      in  lookup reported a tag hit
//   hit_way  in  way that hit
//   way      out way to access or fill
//   evict    out a valid line is displaced
// Priority: in-range hit, then lowest invalid way, then oldest way
// (ties to the lowest index).
module victim_select #(
    parameter int N_WAYS = 2,
    parameter int N_POW  = 4,
    parameter int AGE_W  = 8
) (
    input  logic [N_WAYS-1:0]       valid,
    input  logic [N_WAYS*AGE_W-1:0] ages,
    input  logic                    hit,
    input  logic [N_POW-1:0]        hit_way,
    output logic [N_POW-1:0]        way,
    output logic                    evict
);

    logic [N_POW-1:0] free_way_s;
    logic [N_POW-1:0] old_way_s;
    logic [AGE_W-1:0] best_age_s;
    logic             hit_ok_s;

    // Rank candidates and pick the final way.
    always_comb begin
        free_way_s = '0;
        old_way_s  = '0;
        best_age_s = ages[AGE_W-1:0];
        // An out-of-range hit way cannot be trusted, so it falls back to the miss path.
        hit_ok_s   = hit && ({1'b0, hit_way} < (N_POW+1)'(N_WAYS));
        // Descending scan so the lowest invalid index wins.
        for (int i = N_WAYS - 1; i >= 0; i--) begin
            free_way_s = (!valid[i]) ? N_POW'(i) : free_way_s;
        end
        // Strict greater-than keeps the lowest index on ties.
        for (int i = 1; i < N_WAYS; i++) begin
            old_way_s  = (ages[i*AGE_W +: AGE_W] > best_age_s) ? N_POW'(i) : old_way_s;
            best_age_s = (ages[i*AGE_W +: AGE_W] > best_age_s) ? ages[i*AGE_W +: AGE_W] : best_age_s;
        end
        if (hit_ok_s) begin
            way   = hit_way;
            evict = 1'b0;
        end else if (!(&valid)) begin
            way   = free_way_s;
            evict = 1'b0;
        end else begin
            way   = old_way_s;
            evict = 1'b1;
        end
    end

endmodule

// File: rtl/cache_repl_ctrl.sv
// cache_repl_ctrl: per-set replacement controller (valid bits + saturating
// ages) with a one-set-per-cycle whole-cache flush.
//   clk, rst                 clock, synchronous active-high reset
//   acc_valid/acc_ready      access handshake; acc_set, acc_hit, acc_way
//   rsp_valid/rsp_ready      response handshake; rsp_way, rsp_evict
//   flush_req / flush_busy   level flush request / flush in progress
// Optional: `define CACHE_REPL_STATS_EN adds stat_hits, stat_misses,
// stat_evicts (32-bit, wrapping, cleared by rst only).
module cache_repl_ctrl
    import cache_repl_pkg::*;
#(
    parameter int N_WAYS   = DEF_N_WAYS,
    parameter int N_POW    = DEF_N_POW,
    parameter int N_SETS   = DEF_N_SETS,
    parameter int SET_BITS = DEF_SET_BITS,
    parameter int AGE_W    = DEF_AGE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                acc_valid,
    output logic                acc_ready,
    input  logic [SET_BITS-1:0] acc_set,
    input  logic                acc_hit,
    input  logic [N_POW-1:0]    acc_way,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [N_POW-1:0]    rsp_way,
    output logic                rsp_evict,
`ifdef CACHE_REPL_STATS_EN
    output logic [31:0]         stat_hits,
    output logic [31:0]         stat_misses,
    output logic [31:0]         stat_evicts,
`endif
    input  logic                flush_req,
    output logic                flush_busy
);

    repl_state_t         state_r;
    logic [N_WAYS-1:0]   valid_r [N_SETS];
    logic [AGE_W-1:0]    age_r   [N_SETS][N_WAYS];
    logic [SET_BITS-1:0] flush_cnt_r;
    logic                acc_ready_r;
    logic                rsp_valid_r;
    logic [N_POW-1:0]    rsp_way_r;
    logic                rsp_evict_r;
    logic                flush_busy_r;

    logic [N_WAYS*AGE_W-1:0] set_ages_s;
    logic [N_POW-1:0]        sel_way_s;
    logic                    sel_evict_s;

    // Flatten the addressed set's ages for the victim chooser.
    always_comb begin
        set_ages_s = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            set_ages_s[w*AGE_W +: AGE_W] = age_r[acc_set][w];
        end
    end

    victim_select #(
        .N_WAYS (N_WAYS),
        .N_POW  (N_POW),
        .AGE_W  (AGE_W)
    ) u_victim_select (
        .valid   (valid_r[acc_set]),
        .ages    (set_ages_s),
        .hit     (acc_hit),
        .hit_way (acc_way),
        .way     (sel_way_s),
        .evict   (sel_evict_s)
    );

    // Controller FSM, replacement state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            flush_cnt_r  <= '0;
            acc_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
            rsp_way_r    <= '0;
            rsp_evict_r  <= 1'b0;
            flush_busy_r <= 1'b0;
            for (int s = 0; s < N_SETS; s++) begin
                valid_r[s] <= '0;
                for (int w = 0; w < N_WAYS; w++) begin
                    age_r[s][w] <= '0;
                end
            end
        end else begin
            case (state_r)
                IDLE: begin
                    // Flush wins over a simultaneous access; that access is left pending.
                    if (flush_req) begin
                        state_r      <= FLUSH;
                        acc_ready_r  <= 1'b0;
                        flush_busy_r <= 1'b1;
                        flush_cnt_r  <= '0;
                    end else if (acc_valid) begin
                        state_r     <= RESP;
                        acc_ready_r <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_way_r   <= sel_way_s;
                        rsp_evict_r <= sel_evict_s;
                        valid_r[acc_set][int'(sel_way_s)] <= 1'b1;
                        for (int w = 0; w < N_WAYS; w++) begin
                            if (w == int'(sel_way_s)) begin
                                age_r[acc_set][w] <= '0;
                            end else if (valid_r[acc_set][w] && (age_r[acc_set][w] != '1)) begin
                                age_r[acc_set][w] <= age_r[acc_set][w] + 1'b1;
                            end else begin
                                age_r[acc_set][w] <= age_r[acc_set][w];
                            end
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r     <= IDLE;
                        acc_ready_r <= 1'b1;
                        rsp_valid_r <= 1'b0;
                        rsp_way_r   <= '0;
                        rsp_evict_r <= 1'b0;
                    end else begin
                        state_r <= RESP;
                    end
                end
                FLUSH: begin
                    valid_r[flush_cnt_r] <= '0;
                    for (int w = 0; w < N_WAYS; w++) begin
                        age_r[flush_cnt_r][w] <= '0;
                    end
                    if (flush_cnt_r == SET_BITS'(N_SETS - 1)) begin
                        state_r      <= IDLE;
                        acc_ready_r  <= 1'b1;
                        flush_busy_r <= 1'b0;
                        flush_cnt_r  <= '0;
                    end else begin
                        flush_cnt_r <= flush_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    acc_ready_r  <= 1'b1;
                    rsp_valid_r  <= 1'b0;
                    flush_busy_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef CACHE_REPL_STATS_EN
    logic [31:0] stat_hits_r;
    logic [31:0] stat_misses_r;
    logic [31:0] stat_evicts_r;
    logic        eff_hit_s;

    // Only in-range hits count as hits; everything else took the miss path.
    always_comb begin
        eff_hit_s = acc_hit && ({1'b0, acc_way} < (N_POW+1)'(N_WAYS));
    end

    // Access statistics, updated on each accepted access; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits_r   <= 32'd0;
            stat_misses_r <= 32'd0;
            stat_evicts_r <= 32'd0;
        end else if ((state_r == IDLE) && !flush_req && acc_valid) begin
            stat_hits_r   <= stat_hits_r   + {31'd0, eff_hit_s};
            stat_misses_r <= stat_misses_r + {31'd0, !eff_hit_s};
            stat_evicts_r <= stat_evicts_r + {31'd0, sel_evict_s};
        end else begin
            stat_hits_r   <= stat_hits_r;
        end
    end

    assign stat_hits   = stat_hits_r;
    assign stat_misses = stat_misses_r;
    assign stat_evicts = stat_evicts_r;
`endif

    assign acc_ready  = acc_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_way    = rsp_way_r;
    assign rsp_evict  = rsp_evict_r;
    assign flush_busy = flush_busy_r;

endmodule
